// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for an MSP430-style CPU: steps each instruction through
// fetch, extension words, operand reads, execute and write-back, stalling on mem_rdy.
module cpu_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFE,
  parameter int          STATE_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         As,
  input  logic               Ad,
  input  logic               BW,
  input  logic               OneOp,
  input  logic               IsJump,
  input  logic               JmpTaken,
  input  logic [2:0]         OpII,
  input  logic [3:0]         srcA,
  input  logic [3:0]         dstA,
  input  logic               mem_rdy,
  output logic               mem_req,
  output logic               mem_we,
  output logic [1:0]         mab_sel,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               pc_branch,
  output logic               pc_load_mdb,
  output logic [1:0]         ext_load,
  output logic [1:0]         op_load,
  output logic               rs_autoinc,
  output logic               sp_dec,
  output logic               alu_en,
  output logic               reg_we,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    RST_VEC = 4'd0,
    FETCH   = 4'd1,
    SRC_EXT = 4'd2,
    SRC_RD  = 4'd3,
    DST_EXT = 4'd4,
    DST_RD  = 4'd5,
    EXEC    = 4'd6,
    WB_MEM  = 4'd7,
    PUSH_WR = 4'd8
  } state_t;

  state_t r_state;
  state_t w_next;
  state_t w_postSrc;
  state_t w_postFetch;

  logic [3:0] w_srcReg;
  logic       w_constGen;
  logic       w_reti;
  logic       w_push;
  logic       w_call;
  logic       w_srcAccess;
  logic       w_imm;
  logic       w_dstMem;
  logic       w_wbMem;
  logic       w_unused;

  // Byte width and the vector address only matter to the datapath.
  assign w_unused = ^{BW, RESET_VECTOR};

  // Format II instructions address their single operand through As/dstA.
  assign w_srcReg    = OneOp ? dstA : srcA;
  assign w_constGen  = (w_srcReg == 4'd3) || ((w_srcReg == 4'd2) && As[1]);
  assign w_reti      = OneOp && (OpII == 3'b110);
  assign w_push      = OneOp && (OpII[2:1] == 2'b10);
  assign w_call      = OneOp && (OpII == 3'b101);
  assign w_srcAccess = !IsJump && !w_reti && (As != 2'b00) && !w_constGen;
  assign w_imm       = (As == 2'b11) && (w_srcReg == 4'd0);
  assign w_dstMem    = !OneOp && Ad;
  assign w_wbMem     = w_dstMem || (OneOp && !w_push && !w_reti && (As != 2'b00));

  assign w_postSrc   = w_dstMem ? DST_EXT : EXEC;
  assign w_postFetch = IsJump                          ? EXEC      :
                       !w_srcAccess                    ? w_postSrc :
                       ((As == 2'b01) || w_imm)        ? SRC_EXT   : SRC_RD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RST_VEC;
    else        r_state <= w_next;
  end

  // Outputs are forced quiet while reset is held, even though RST_VEC is a memory state.
  always_comb begin
    w_next      = r_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mab_sel     = 2'd0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_branch   = 1'b0;
    pc_load_mdb = 1'b0;
    ext_load    = 2'b00;
    op_load     = 2'b00;
    rs_autoinc  = 1'b0;
    sp_dec      = 1'b0;
    alu_en      = 1'b0;
    reg_we      = 1'b0;
    if (rst_n) begin
      case (r_state)
        RST_VEC: begin
          mem_req = 1'b1;
          if (mem_rdy) begin
            pc_load_mdb = 1'b1;
            w_next      = FETCH;
          end
        end
        FETCH: begin
          mem_req = 1'b1;
          if (mem_rdy) begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
            w_next  = w_postFetch;
          end
        end
        SRC_EXT: begin
          mem_req = 1'b1;
          if (mem_rdy) begin
            ext_load = 2'b01;
            pc_inc   = 1'b1;
            w_next   = (As == 2'b01) ? SRC_RD : w_postSrc;
          end
        end
        SRC_RD: begin
          mem_req = 1'b1;
          mab_sel = 2'd1;
          if (mem_rdy) begin
            op_load    = 2'b01;
            rs_autoinc = (As == 2'b11);
            w_next     = w_postSrc;
          end
        end
        DST_EXT: begin
          mem_req = 1'b1;
          if (mem_rdy) begin
            ext_load = 2'b10;
            pc_inc   = 1'b1;
            w_next   = DST_RD;
          end
        end
        DST_RD: begin
          mem_req = 1'b1;
          mab_sel = 2'd2;
          if (mem_rdy) begin
            op_load = 2'b10;
            w_next  = EXEC;
          end
        end
        EXEC: begin
          alu_en = 1'b1;
          if (IsJump) begin
            pc_branch = JmpTaken;
            w_next    = FETCH;
          end else if (w_push) begin
            sp_dec = 1'b1;
            w_next = PUSH_WR;
          end else if (w_wbMem) begin
            w_next = WB_MEM;
          end else begin
            reg_we = !w_reti;
            w_next = FETCH;
          end
        end
        WB_MEM: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          mab_sel = 2'd2;
          if (mem_rdy) w_next = FETCH;
        end
        PUSH_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          mab_sel = 2'd3;
          if (mem_rdy) begin
            pc_load_mdb = w_call;
            w_next      = FETCH;
          end
        end
        default: w_next = RST_VEC;
      endcase
    end
  end

  assign state = STATE_W'(r_state);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer: a per-instruction list of expected steps is built
// from the addressing-mode rules and compared against the DUT on every cycle.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] As;
  logic       Ad, BW, OneOp, IsJump, JmpTaken;
  logic [2:0] OpII;
  logic [3:0] srcA, dstA;
  logic       mem_rdy;
  logic       mem_req, mem_we;
  logic [1:0] mab_sel;
  logic       ir_load, pc_inc, pc_branch, pc_load_mdb;
  logic [1:0] ext_load, op_load;
  logic       rs_autoinc, sp_dec, alu_en, reg_we;
  logic [3:0] state;

  cpu_sequencer #(.RESET_VECTOR(16'hFFFE), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .As(As), .Ad(Ad), .BW(BW), .OneOp(OneOp),
    .IsJump(IsJump), .JmpTaken(JmpTaken), .OpII(OpII), .srcA(srcA), .dstA(dstA),
    .mem_rdy(mem_rdy), .mem_req(mem_req), .mem_we(mem_we), .mab_sel(mab_sel),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_branch(pc_branch),
    .pc_load_mdb(pc_load_mdb), .ext_load(ext_load), .op_load(op_load),
    .rs_autoinc(rs_autoinc), .sp_dec(sp_dec), .alu_en(alu_en), .reg_we(reg_we),
    .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] ST_RST = 4'd0, ST_FETCH = 4'd1, ST_SEXT = 4'd2, ST_SRD = 4'd3,
                         ST_DEXT = 4'd4, ST_DRD = 4'd5, ST_EXEC = 4'd6, ST_WB = 4'd7,
                         ST_PUSH = 4'd8;

  localparam logic [11:0] B_IR = 12'h800, B_PCINC = 12'h400, B_PCBR = 12'h200,
                          B_PCMDB = 12'h100, B_EXT1 = 12'h080, B_EXT0 = 12'h040,
                          B_OP1 = 12'h020, B_OP0 = 12'h010, B_AUTO = 12'h008,
                          B_SPDEC = 12'h004, B_ALU = 12'h002, B_REGWE = 12'h001;

  typedef struct {
    logic [3:0]  st;
    logic        mem;
    logic        we;
    logic [1:0]  sel;
    logic [11:0] strb;
  } step_t;

  typedef struct {
    logic [1:0] as;
    logic       ad, bw, oneOp, isJump, taken;
    logic [2:0] op;
    logic [3:0] src, dst;
  } instr_t;

  step_t q[$];
  int    total = 0;
  int    bad   = 0;

  logic [19:0] got;
  assign got = {state, mem_req, mem_we, mab_sel, ir_load, pc_inc, pc_branch, pc_load_mdb,
                ext_load, op_load, rs_autoinc, sp_dec, alu_en, reg_we};

  function automatic step_t mk(logic [3:0] st, logic mem, logic we, logic [1:0] sel,
                               logic [11:0] strb);
    step_t s;
    s.st = st; s.mem = mem; s.we = we; s.sel = sel; s.strb = strb;
    return s;
  endfunction

  function automatic instr_t mkInstr(logic [1:0] as, logic ad, logic oneOp, logic isJump,
                                     logic taken, logic [2:0] op, logic [3:0] src,
                                     logic [3:0] dst);
    instr_t t;
    t.as = as; t.ad = ad; t.bw = 1'b0; t.oneOp = oneOp; t.isJump = isJump;
    t.taken = taken; t.op = op; t.src = src; t.dst = dst;
    return t;
  endfunction

  // Drive the decoded fields and queue the steps the instruction must walk through.
  task automatic applyStimulus(input instr_t t);
    logic [3:0] r;
    logic       reti, pushLike, constGen, memDst;
    As = t.as; Ad = t.ad; BW = t.bw; OneOp = t.oneOp; IsJump = t.isJump;
    JmpTaken = t.taken; OpII = t.op; srcA = t.src; dstA = t.dst;
    q.push_back(mk(ST_FETCH, 1, 0, 2'd0, B_IR | B_PCINC));
    if (t.isJump) begin
      q.push_back(mk(ST_EXEC, 0, 0, 2'd0, B_ALU | (t.taken ? B_PCBR : 12'h000)));
      return;
    end
    r        = t.oneOp ? t.dst : t.src;
    reti     = t.oneOp && (t.op == 3'd6);
    pushLike = t.oneOp && ((t.op == 3'd4) || (t.op == 3'd5));
    constGen = (r == 4'd3) || ((r == 4'd2) && (t.as >= 2'd2));
    memDst   = (!t.oneOp && t.ad) || (t.oneOp && !reti && !pushLike && (t.as != 2'd0));
    if (!reti && !constGen) begin
      if (t.as == 2'd1) begin
        q.push_back(mk(ST_SEXT, 1, 0, 2'd0, B_EXT0 | B_PCINC));
        q.push_back(mk(ST_SRD, 1, 0, 2'd1, B_OP0));
      end else if (t.as == 2'd2) begin
        q.push_back(mk(ST_SRD, 1, 0, 2'd1, B_OP0));
      end else if (t.as == 2'd3 && r == 4'd0) begin
        q.push_back(mk(ST_SEXT, 1, 0, 2'd0, B_EXT0 | B_PCINC));
      end else if (t.as == 2'd3) begin
        q.push_back(mk(ST_SRD, 1, 0, 2'd1, B_OP0 | B_AUTO));
      end
    end
    if (!t.oneOp && t.ad) begin
      q.push_back(mk(ST_DEXT, 1, 0, 2'd0, B_EXT1 | B_PCINC));
      q.push_back(mk(ST_DRD, 1, 0, 2'd2, B_OP1));
    end
    if (pushLike) begin
      q.push_back(mk(ST_EXEC, 0, 0, 2'd0, B_ALU | B_SPDEC));
      q.push_back(mk(ST_PUSH, 1, 1, 2'd3, (t.op == 3'd5) ? B_PCMDB : 12'h000));
    end else if (memDst) begin
      q.push_back(mk(ST_EXEC, 0, 0, 2'd0, B_ALU));
      q.push_back(mk(ST_WB, 1, 1, 2'd2, 12'h000));
    end else begin
      q.push_back(mk(ST_EXEC, 0, 0, 2'd0, B_ALU | (reti ? 12'h000 : B_REGWE)));
    end
  endtask

  task automatic checkOutput(input string name, input logic [19:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%05h expected=%05h", name, got, exp);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // mode 0: random mem_rdy; 1: always ready; 2: three stall cycles in SRC_RD.
  task automatic runSteps(input int mode, input int abortSt, output int cycles);
    step_t s;
    int    stalls;
    cycles = 0;
    stalls = 0;
    while (q.size() > 0) begin
      s = q[0];
      if (mode == 0)                                    mem_rdy = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && s.st == ST_SRD && stalls < 3) begin
        mem_rdy = 1'b0;
        stalls++;
      end else                                          mem_rdy = 1'b1;
      if (abortSt >= 0 && int'(s.st) == abortSt) mem_rdy = 1'b0;
      @(negedge clk);
      checkOutput("step", {s.st, s.mem, s.we, s.sel,
                           (s.mem && !mem_rdy) ? 12'h000 : s.strb});
      cycles++;
      if (abortSt >= 0 && int'(s.st) == abortSt) begin
        #1 rst_n = 1'b0;
        #1 checkOutput("abort_reset", 20'h00000);
        q.delete();
        return;
      end
      if (!s.mem || mem_rdy) void'(q.pop_front());
      if (cycles > 100) begin
        checkValue("timeout", cycles, 100);
        q.delete();
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int     cyc;
    instr_t t;
    rst_n = 1'b0; mem_rdy = 1'b0;
    As = 2'd0; Ad = 1'b0; BW = 1'b0; OneOp = 1'b0; IsJump = 1'b0; JmpTaken = 1'b0;
    OpII = 3'd0; srcA = 4'd0; dstA = 4'd0;

    @(negedge clk);
    checkOutput("reset_idle", 20'h00000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    q.push_back(mk(ST_RST, 1, 0, 2'd0, B_PCMDB));
    runSteps(1, -1, cyc);
    checkValue("rstvec_latency", cyc, 1);

    applyStimulus(mkInstr(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd5, 4'd6));
    runSteps(1, -1, cyc);
    checkValue("mov_rr_latency", cyc, 2);

    applyStimulus(mkInstr(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd4, 4'd7));
    runSteps(1, -1, cyc);
    checkValue("add_autoinc_idx_latency", cyc, 6);

    applyStimulus(mkInstr(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd5));
    runSteps(1, -1, cyc);
    checkValue("add_imm_latency", cyc, 3);

    applyStimulus(mkInstr(2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'd0, 4'd0));
    runSteps(1, -1, cyc);
    checkValue("jump_latency", cyc, 2);

    applyStimulus(mkInstr(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd4, 4'd6));
    runSteps(2, -1, cyc);
    checkValue("src_rd_stall_latency", cyc, 6);

    for (int i = 0; i < 300; i++) begin
      t = mkInstr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      t.bw = 1'($urandom_range(0, 1));
      applyStimulus(t);
      runSteps(0, -1, cyc);
    end

    applyStimulus(mkInstr(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 4'd0, 4'd9));
    runSteps(1, int'(ST_PUSH), cyc);
    checkValue("call_cycles_to_push_wr", cyc, 3);
    @(posedge clk);
    #1 rst_n = 1'b1;
    q.push_back(mk(ST_RST, 1, 0, 2'd0, B_PCMDB));
    runSteps(0, -1, cyc);
    applyStimulus(mkInstr(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd2, 4'd8));
    runSteps(1, -1, cyc);
    checkValue("abs_to_idx_latency", cyc, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
